// File: rtl/studio2_keypad.sv
// Studio II keypad front end: PS/2 make/break -> two 10-key matrices with minimum-hold
// stretching, plus OUT 2 key select and EF3_n/EF4_n poll. Keypad 2 built only with STUDIO2_KEYPAD2_EN.

module studio2_keypad_pad #(
  parameter int MIN_HOLD = 50000,
  parameter int HOLD_W   = 16,
  parameter bit PAD2     = 1'b0
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ev,
  input  logic       make,
  input  logic [7:0] code,
  output logic [9:0] keys
);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(MIN_HOLD);

  logic [9:0]        pressed_q, pressed_d;
  logic [9:0]        pend_q, pend_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              hit;
  logic [3:0]        idx;

  always_comb begin
    hit = 1'b1;
    idx = 4'd0;
    if (!PAD2) begin
      case (code)
        8'h45: idx = 4'd0;
        8'h16: idx = 4'd1;
        8'h1E: idx = 4'd2;
        8'h26: idx = 4'd3;
        8'h25: idx = 4'd4;
        8'h2E: idx = 4'd5;
        8'h36: idx = 4'd6;
        8'h3D: idx = 4'd7;
        8'h3E: idx = 4'd8;
        8'h46: idx = 4'd9;
        default: hit = 1'b0;
      endcase
    end else begin
      case (code)
        8'h70: idx = 4'd0;
        8'h69: idx = 4'd1;
        8'h72: idx = 4'd2;
        8'h7A: idx = 4'd3;
        8'h6B: idx = 4'd4;
        8'h73: idx = 4'd5;
        8'h74: idx = 4'd6;
        8'h6C: idx = 4'd7;
        8'h75: idx = 4'd8;
        8'h7D: idx = 4'd9;
        default: hit = 1'b0;
      endcase
    end
  end

  // Expiry is resolved first so an event in the same cycle sees the post-expiry state.
  always_comb begin
    pressed_d = pressed_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - HOLD_W'(1);
      if (cnt_q == HOLD_W'(1)) begin
        pressed_d = pressed_d & ~pend_q;
        pend_d    = '0;
      end
    end
    if (ev && hit) begin
      if (make) begin
        pressed_d[idx] = 1'b1;
        pend_d[idx]    = 1'b0;
        cnt_d          = HOLD_INIT;
      end else if (cnt_d == '0) begin
        pressed_d[idx] = 1'b0;
      end else begin
        pend_d[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pressed_q <= '0;
      pend_q    <= '0;
      cnt_q     <= '0;
    end else begin
      pressed_q <= pressed_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
    end
  end

  assign keys = pressed_q;
endmodule

module studio2_keypad #(
  parameter int MIN_HOLD = 50000,
  parameter int HOLD_W   = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic        io_out,
  input  logic [2:0]  io_n,
  input  logic [7:0]  cpu_dout,
  output logic [3:0]  key_sel,
  output logic [9:0]  kp1_keys,
  output logic [9:0]  kp2_keys,
  output logic        ef3_n,
  output logic        ef4_n
);
  logic       old_toggle_q, old_toggle_d;
  logic       primed_q, primed_d;
  logic [3:0] key_sel_q, key_sel_d;
  logic       ef3_n_q, ef3_n_d;
  logic       ev;
  logic [15:0] kp1_ext;

  // The first post-reset cycle only captures the toggle bit so a stale level isn't an event.
  assign ev = primed_q && (ps2_key[10] != old_toggle_q) && !ps2_key[8];
  assign kp1_ext = {6'd0, kp1_keys};

  always_comb begin
    old_toggle_d = ps2_key[10];
    primed_d     = 1'b1;
    key_sel_d    = key_sel_q;
    if (io_out && io_n == 3'd2) key_sel_d = cpu_dout[3:0];
    ef3_n_d = ~kp1_ext[key_sel_q];
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      old_toggle_q <= 1'b0;
      primed_q     <= 1'b0;
      key_sel_q    <= 4'd0;
      ef3_n_q      <= 1'b1;
    end else begin
      old_toggle_q <= old_toggle_d;
      primed_q     <= primed_d;
      key_sel_q    <= key_sel_d;
      ef3_n_q      <= ef3_n_d;
    end
  end

  studio2_keypad_pad #(.MIN_HOLD(MIN_HOLD), .HOLD_W(HOLD_W), .PAD2(1'b0)) u_pad1 (
    .clk_sys(clk_sys), .reset(reset), .ev(ev), .make(ps2_key[9]),
    .code(ps2_key[7:0]), .keys(kp1_keys)
  );

`ifdef STUDIO2_KEYPAD2_EN
  logic        ef4_n_q, ef4_n_d;
  logic [15:0] kp2_ext;

  assign kp2_ext = {6'd0, kp2_keys};

  always_comb begin
    ef4_n_d = ~kp2_ext[key_sel_q];
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) ef4_n_q <= 1'b1;
    else       ef4_n_q <= ef4_n_d;
  end

  studio2_keypad_pad #(.MIN_HOLD(MIN_HOLD), .HOLD_W(HOLD_W), .PAD2(1'b1)) u_pad2 (
    .clk_sys(clk_sys), .reset(reset), .ev(ev), .make(ps2_key[9]),
    .code(ps2_key[7:0]), .keys(kp2_keys)
  );
  assign ef4_n = ef4_n_q;
`else
  assign kp2_keys = '0;
  assign ef4_n    = 1'b1;
`endif

  assign key_sel = key_sel_q;
  assign ef3_n   = ef3_n_q;
endmodule

// File: doc/studio2_keypad.md
# studio2_keypad

Keypad front end for the Studio II core: converts PS/2 make/break events into two 10-key keypad matrices (player 1, player 2) and answers the CPU's key poll. Sits between the PS/2 input and the CDP1802: the CPU writes a key number with OUT 2, and the block drives EF3_n/EF4_n low while that key is held on keypad 1/2. A minimum-hold stretch guarantees short taps survive until the game's polling loop samples them.

## Interface
- MIN_HOLD, 50000: minimum clk_sys cycles a key stays reported pressed after its make event; 0 disables stretching.
- HOLD_W, 16: width of hold counters; MIN_HOLD < 2^HOLD_W.
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ps2_key  in  11  [10] toggle per event, [9] 1=make/0=break, [8] extended, [7:0] scan code.
- io_out  in  1  CPU output strobe, one clk_sys cycle per OUT instruction.
- io_n  in  3  CPU N lines during io_out.
- cpu_dout  in  8  CPU output data during io_out.
- key_sel  out  4  latched key number from last OUT 2.
- kp1_keys  out  10  effective pressed mask, keypad 1, bit k = key k.
- kp2_keys  out  10  effective pressed mask, keypad 2.
- ef3_n  out  1  low = selected key pressed on keypad 1.
- ef4_n  out  1  low = selected key pressed on keypad 2.

## Operation
- Event detect: old_toggle register; event when ps2_key[10] != old_toggle. First cycle after reset is a prime cycle: old_toggle loads ps2_key[10], no decode.
- Decode (ps2_key[8] must be 0, else ignored): keypad 1 keys 0-9 = codes 45,16,1E,26,25,2E,36,3D,3E,46 (main row); keypad 2 keys 0-9 = 70,69,72,7A,6B,73,74,6C,75,7D (numeric pad). Other codes ignored.
- Per keypad p: pressed[9:0], pend_rel[9:0], hold_cnt[HOLD_W-1:0].
- Make of key k: pressed[k]<=1, pend_rel[k]<=0, hold_cnt<=MIN_HOLD. Repeated make (typematic) restarts hold_cnt.
- Break of key k: if hold_cnt==0 then pressed[k]<=0; else pend_rel[k]<=1.
- hold_cnt != 0 decrements each cycle; on the 1->0 step: pressed <= pressed & ~pend_rel, pend_rel<=0.
- Same-cycle expiry and event: expiry applied first, event applied on the result.
- Select: io_out && io_n==3'd2 -> key_sel <= cpu_dout[3:0]. Other N values ignored.
- ef3_n <= ~(key_sel<=9 && kp1_keys[key_sel]); ef4_n likewise from kp2_keys. key_sel 10-15 -> both high.
- kp1_keys/kp2_keys = pressed registers directly.

## Timing
- Reset values: key_sel=0, kp1_keys=kp2_keys=0, ef3_n=ef4_n=1, all hold_cnt=0, pend_rel=0, old_toggle=0.
- Event -> kpX_keys: 1 cycle after ps2_key[10] toggles. -> efX_n: 2 cycles.
- OUT 2 -> efX_n reflects new key_sel: 2 cycles after io_out cycle (key_sel 1 cycle).
- Tap (make then break within MIN_HOLD): key reported for exactly MIN_HOLD cycles from make-registered cycle.
- Reset asserted mid-hold: everything returns to reset values immediately; no pending release survives.

## Configuration
- STUDIO2_KEYPAD2_EN defined: keypad 2 decoded as above.
- Not defined: numeric-pad codes ignored, kp2_keys tied 0, ef4_n tied 1, no keypad-2 counters/registers synthesized.

## Test plan
- Reset then idle: ef3_n=ef4_n=1, key_sel=0, masks 0; ps2_key[10]=1 at reset release produces no event.
- OUT 2 data 0x05, make code 2E (MIN_HOLD=0): kp1_keys=0x020 after 1 cycle, ef3_n=0 after 2; break 2E -> ef3_n=1 two cycles later.
- MIN_HOLD=100: make 16 then break 16 after 10 cycles, key_sel=1: ef3_n stays 0 until 100 cycles after make, then 1.
- Keypad 2 (macro on), key_sel=9: make 7D -> ef4_n=0, ef3_n=1; macro off: ef4_n stays 1, kp2_keys=0.
- key_sel=0x0C via OUT 2 with key 0 on both pads held: ef3_n=ef4_n=1; OUT 6 with 0x00 leaves key_sel=0x0C.
- Make 45 with ps2_key[8]=1 and unmapped code 1C: no mask change; reset during hold of key 3: kp1_keys=0 immediately.
